// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl: circular byte FIFO stored in a dual-port SRAM.
// Port 1 only writes and port 2 only reads. A 2-stage read pipe (S1 drives
// CEB2, S2 sees Q2) feeds a 3-entry out-buffer. The out-buffer is a registered
// head (rd_data) plus a 2-entry skid.
// Optional: define SRAM_FIFO_OVF_CNT_EN to build the saturating overrun counter.
module sram_fifo_ctrl #(
  parameter int AW = 10,
  parameter int DW = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          wr_valid,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ready,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  input  logic          rd_ready,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic [7:0]    ovf_cnt,
  output logic          CEB1,
  output logic          CMD1,
  output logic [AW-1:0] ADD1,
  output logic [DW-1:0] DIN1,
  output logic          CEB2,
  output logic          CMD2,
  output logic [AW-1:0] ADD2,
  input  logic [DW-1:0] Q2
);
  localparam int            STAGES = 1;
  localparam logic [AW:0]   DEPTH  = (AW+1)'(2**AW);

  logic [AW-1:0]        wptr, rptr;
  logic [AW:0]          avail;
  logic [STAGES:0]      vld_pipe;   // [0] = S1 (CEB2 low), [1] = S2 (Q2 valid)
  logic [1:0][DW-1:0]   sk, sk_n;
  logic [1:0]           sk_occ, sk_occ_n;
  logic                 hd_vld_n;
  logic [DW-1:0]        hd_n;
  logic                 acc, pop, issue, cap, commit;
  logic [2:0]           occ_post;

  assign CMD1     = 1'b0;
  assign CMD2     = 1'b1;
  assign CEB2     = ~vld_pipe[0];
  assign full     = (count == DEPTH);
  assign empty    = (count == '0);
  assign wr_ready = ~full;
  assign acc      = wr_valid & wr_ready;
  assign pop      = rd_valid & rd_ready;
  assign cap      = vld_pipe[STAGES];
  assign commit   = ~CEB1;

  // Slots claimed downstream after this edge's pop; in-flight reads already own one.
  assign occ_post = {2'b0, rd_valid} + {1'b0, sk_occ} - {2'b0, pop}
                  + {2'b0, vld_pipe[0]} + {2'b0, vld_pipe[1]};
  // avail only counts committed writes, so a read never races its own write.
  assign issue    = (avail != '0) && (occ_post < 3'd3);

  // Write port: one SRAM write per accepted byte, enable drops when idle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      CEB1 <= 1'b1;
      ADD1 <= '0;
      DIN1 <= '0;
      wptr <= '0;
    end else if (acc) begin
      CEB1 <= 1'b0;
      ADD1 <= wptr;
      DIN1 <= wr_data;
      wptr <= wptr + 1'b1;
    end else begin
      CEB1 <= 1'b1;
    end
  end

  // Committed-but-unissued entry count.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) avail <= '0;
    else begin
      case ({commit, issue})
        2'b10:   avail <= avail + 1'b1;
        2'b01:   avail <= avail - 1'b1;
        default: avail <= avail;
      endcase
    end
  end

  // Read issue and read pipe valid shift register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vld_pipe <= '0;
      rptr     <= '0;
      ADD2     <= '0;
    end else begin
      vld_pipe[0]        <= issue;
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      if (issue) begin
        ADD2 <= rptr;
        rptr <= rptr + 1'b1;
      end
    end
  end

  // Out-buffer next state: drop popped head, refill from skid, then place capture.
  always_comb begin
    hd_vld_n = rd_valid;
    hd_n     = rd_data;
    sk_n     = sk;
    sk_occ_n = sk_occ;
    if (pop) hd_vld_n = 1'b0;
    if (!hd_vld_n && sk_occ != 2'd0) begin
      hd_vld_n = 1'b1;
      hd_n     = sk[0];
      sk_n[0]  = sk[1];
      sk_occ_n = sk_occ - 1'b1;
    end
    if (cap) begin
      if (!hd_vld_n) begin
        hd_vld_n = 1'b1;
        hd_n     = Q2;
      end else begin
        sk_n[sk_occ_n[0]] = Q2;
        sk_occ_n          = sk_occ_n + 1'b1;
      end
    end
  end

  // Out-buffer registers; rd_data keeps its last value when empty.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      sk       <= '0;
      sk_occ   <= '0;
    end else begin
      rd_valid <= hd_vld_n;
      rd_data  <= hd_n;
      sk       <= sk_n;
      sk_occ   <= sk_occ_n;
    end
  end

  // Occupancy: accepted minus delivered.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) count <= '0;
    else begin
      case ({acc, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef SRAM_FIFO_OVF_CNT_EN
  // Saturating count of writes offered while full.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) ovf_cnt <= '0;
    else if (wr_valid && !wr_ready && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 1'b1;
  end
`else
  assign ovf_cnt = '0;
`endif

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Bench for sram_fifo_ctrl: SRAM model, queue-based FIFO model checked every
// cycle, and directed scenarios with literal expectations.
module tb_sram_fifo_ctrl;
  localparam int AW = 10;
  localparam int DW = 8;
  localparam int DEPTH = 1024;

  logic          CLK, RST;
  logic          wr_valid, wr_ready, rd_valid, rd_ready;
  logic [DW-1:0] wr_data, rd_data;
  logic [AW:0]   count;
  logic          full, empty;
  logic [7:0]    ovf_cnt;
  logic          CEB1, CMD1, CEB2, CMD2;
  logic [AW-1:0] ADD1, ADD2;
  logic [DW-1:0] DIN1, Q2;

  sram_fifo_ctrl #(.AW(AW), .DW(DW)) dut (
    .CLK(CLK), .RST(RST),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
    .count(count), .full(full), .empty(empty), .ovf_cnt(ovf_cnt),
    .CEB1(CEB1), .CMD1(CMD1), .ADD1(ADD1), .DIN1(DIN1),
    .CEB2(CEB2), .CMD2(CMD2), .ADD2(ADD2), .Q2(Q2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // SRAM: write on port 1, registered read on port 2.
  logic [DW-1:0] mem [DEPTH];
  initial Q2 = '0;
  always @(posedge CLK) begin
    if (!CEB1 && !CMD1) mem[ADD1] <= DIN1;
    if (!CEB2 && CMD2)  Q2 <= mem[ADD2];
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: bytes owed downstream, bytes awaiting the SRAM write, counters.
  byte unsigned exp_q[$];
  byte unsigned wq[$];
  int  m_count = 0, m_commit = 0, m_rissue = 0, m_pops = 0, m_ovf = 0;
  bit  run_chk = 0;

  // Per-cycle compare, sampled on the falling edge.
  always @(negedge CLK) begin
    if (RST) begin
      exp_q.delete(); wq.delete();
      m_count = 0; m_commit = 0; m_rissue = 0; m_pops = 0; m_ovf = 0;
    end else if (run_chk) begin
      automatic int pre = m_count;
      chk("count", count, pre);
      chk("full", full, pre == DEPTH);
      chk("empty", empty, pre == 0);
      chk("wr_ready", wr_ready, pre != DEPTH);
      chk("ovf_cnt", ovf_cnt, m_ovf);
      chk("cmd1", CMD1, 0);
      chk("cmd2", CMD2, 1);
      if (pre == 0) chk("rd_valid_when_empty", rd_valid, 0);
      if (!CEB2) begin
        chk("add2", ADD2, m_rissue % DEPTH);
        chk("read_after_commit", m_rissue < m_commit, 1);
        m_rissue++;
      end
      chk("inflight_le3", (m_rissue - m_pops) <= 3, 1);
      if (!CEB1) begin
        if (wq.size() == 0) chk("spurious_write", 1, 0);
        else chk("din1", DIN1, wq.pop_front());
        chk("add1", ADD1, m_commit % DEPTH);
        m_commit++;
      end
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) chk("spurious_pop", 1, 0);
        else chk("rd_data", rd_data, exp_q.pop_front());
        m_pops++;
        m_count--;
      end
      if (wr_valid && pre != DEPTH) begin
        exp_q.push_back(wr_data);
        wq.push_back(wr_data);
        m_count++;
      end
`ifdef SRAM_FIFO_OVF_CNT_EN
      if (wr_valid && pre == DEPTH && m_ovf < 255) m_ovf++;
`endif
    end
  end

  task automatic step();
    @(posedge CLK); #1;
  endtask

  // Assert reset mid-cycle and check outputs clear immediately.
  task automatic do_reset();
    wr_valid = 1'b0; rd_ready = 1'b0;
    @(posedge CLK); #2;
    RST = 1'b1;
    #1;
    chk("rst_ceb1", CEB1, 1);
    chk("rst_ceb2", CEB2, 1);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_count", count, 0);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_add1", ADD1, 0);
    chk("rst_add2", ADD2, 0);
    chk("rst_din1", DIN1, 0);
    chk("rst_ovf", ovf_cnt, 0);
    @(negedge CLK);
    @(posedge CLK); #1;
    RST = 1'b0;
    run_chk = 1'b1;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    wr_valid = 1'b0; rd_ready = 1'b1;
    while (m_count != 0 && n < budget) begin step(); n++; end
    chk("drain_in_budget", n < budget, 1);
    repeat (4) step();
  endtask

  task automatic fill();
    rd_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      wr_valid = 1'b1; wr_data = 8'(i);
      step();
    end
    wr_valid = 1'b0;
  endtask

  initial begin
    RST = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0; wr_data = '0;
    do_reset();

    // Short stream 11,22,33 with rd_ready high.
    rd_ready = 1'b1;
    wr_valid = 1'b1; wr_data = 8'h11; step();
    chk("ss_ceb1", CEB1, 0); chk("ss_add1_0", ADD1, 0); chk("ss_din1", DIN1, 8'h11);
    wr_data = 8'h22; step(); chk("ss_add1_1", ADD1, 1);
    wr_data = 8'h33; step(); chk("ss_add1_2", ADD1, 2);
    wr_valid = 1'b0;
    step(); chk("ss_rd_valid_e3", rd_valid, 0);
    step(); chk("ss_rd_valid_e4", rd_valid, 1); chk("ss_data0", rd_data, 8'h11);
    step(); chk("ss_data1", rd_data, 8'h22);
    step(); chk("ss_data2", rd_data, 8'h33);
    step(); chk("ss_empty_valid", rd_valid, 0); chk("ss_hold_data", rd_data, 8'h33);

    // Fill to full, hold off extra writes, single pop frees a slot.
    do_reset();
    fill();
    chk("fill_count", count, 1024); chk("fill_full", full, 1); chk("fill_wr_ready", wr_ready, 0);
    wr_valid = 1'b1; wr_data = 8'hEE;
    repeat (5) step();
    chk("held_count", count, 1024);
    wr_valid = 1'b0; rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    chk("pop_wr_ready", wr_ready, 1); chk("pop_count", count, 1023);
    wr_valid = 1'b1; wr_data = 8'h5A; step();
    chk("refill_ceb1", CEB1, 0); chk("refill_add1", ADD1, 0); chk("refill_din1", DIN1, 8'h5A);
    drain(3000);

    // Back-pressure: rd_ready 3 low / 1 high.
    for (int i = 0; i < 200; i++) begin
      wr_valid = 1'b1; wr_data = 8'(i); rd_ready = (i % 4 == 3);
      step();
    end
    drain(3000);
    chk("bp_count", count, 0);

    // Long stream through both pointer wraps at full rate.
    rd_ready = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      wr_valid = 1'b1; wr_data = 8'(i * 7 + 3);
      step();
      if (i >= 4) chk("tput_rd_valid", rd_valid, 1);
    end
    for (int i = 0; i < 5; i++) begin
      wr_data = 8'(i + 8'hA0);
      step();
    end
    do_reset();
    chk("wr_rst_empty", empty, 1); chk("wr_rst_rd_valid", rd_valid, 0);
    rd_ready = 1'b1;
    wr_valid = 1'b1; wr_data = 8'h9C; step();
    wr_valid = 1'b0;
    step(); step();
    chk("fresh_ceb2", CEB2, 0); chk("fresh_add2", ADD2, 0);
    step(); step();
    chk("fresh_rd_valid", rd_valid, 1); chk("fresh_rd_data", rd_data, 8'h9C);
    step();

    // Overrun while full.
    do_reset();
    fill();
    wr_valid = 1'b1; wr_data = 8'h77;
    repeat (300) step();
`ifdef SRAM_FIFO_OVF_CNT_EN
    chk("ovf_saturated", ovf_cnt, 255);
`else
    chk("ovf_disabled", ovf_cnt, 0);
`endif
    wr_valid = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
